// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_REQ requesters.
// The winner's request fields are held for the whole transaction, which ends on mem_finish or on timeout.
module mem_port_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_addr,
    input  logic [16*N_REQ-1:0]  req_offset,
    input  logic [N_REQ-1:0]     req_write,
    input  logic [16*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 mem_enable,
    output logic [15:0]          mem_address,
    output logic [15:0]          mem_offset,
    output logic                 mem_write,
    output logic [15:0]          mem_wdata,
    input  logic                 mem_finish
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               en_q, en_d;
    logic               wr_q, wr_d;
    logic [15:0]        maddr_q, maddr_d;
    logic [15:0]        moff_q, moff_d;
    logic [15:0]        mwdata_q, mwdata_d;
    logic [15:0]        haddr_q, haddr_d;
    logic [15:0]        hoff_q, hoff_d;
    logic [15:0]        hwdata_q, hwdata_d;
    logic               hwrite_q, hwrite_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               found;
    int                 pick;
    int                 idx;
    logic               timeout_hit;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = 0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle without mem_finish.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        en_d     = en_q;
        wr_d     = wr_q;
        maddr_d  = maddr_q;
        moff_d   = moff_q;
        mwdata_d = mwdata_q;
        haddr_d  = haddr_q;
        hoff_d   = hoff_q;
        hwdata_d = hwdata_q;
        hwrite_d = hwrite_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    win_d       = PW'(pick);
                    haddr_d     = req_addr[16*pick +: 16];
                    hoff_d      = req_offset[16*pick +: 16];
                    hwdata_d    = req_wdata[16*pick +: 16];
                    hwrite_d    = req_write[pick];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                en_d     = 1'b1;
                wr_d     = hwrite_q;
                maddr_d  = haddr_q;
                moff_d   = hoff_q;
                mwdata_d = hwdata_q;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (mem_finish || timeout_hit) begin
                    // mem_finish takes priority over a coincident timeout
                    if (mem_finish) done_d[win_q] = 1'b1;
                    else            err_d[win_q]  = 1'b1;
                    en_d     = 1'b0;
                    wr_d     = 1'b0;
                    maddr_d  = '0;
                    moff_d   = '0;
                    mwdata_d = '0;
                    state_d  = RELEASE;
                end else begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                end
            end
            RELEASE: begin
                gnt_d    = '0;
                rr_ptr_d = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            maddr_q  <= '0;
            moff_q   <= '0;
            mwdata_q <= '0;
            haddr_q  <= '0;
            hoff_q   <= '0;
            hwdata_q <= '0;
            hwrite_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            wr_q     <= wr_d;
            maddr_q  <= maddr_d;
            moff_q   <= moff_d;
            mwdata_q <= mwdata_d;
            haddr_q  <= haddr_d;
            hoff_q   <= hoff_d;
            hwdata_q <= hwdata_d;
            hwrite_q <= hwrite_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mem_enable  = en_q;
    assign mem_write   = wr_q;
    assign mem_address = maddr_q;
    assign mem_offset  = moff_q;
    assign mem_wdata   = mwdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (3 requesters, TIMEOUT=8).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] req_addr, req_offset, req_wdata;
    logic [2:0]  req_write;
    logic [2:0]  gnt, done, err;
    logic        mem_enable, mem_write, mem_finish;
    logic [15:0] mem_address, mem_offset, mem_wdata;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.N_REQ(3), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_offset(req_offset), .req_write(req_write), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .mem_enable(mem_enable),
        .mem_address(mem_address), .mem_offset(mem_offset), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_finish(mem_finish)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then stable and inputs set here apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; req_addr = '0; req_offset = '0; req_wdata = '0;
        req_write = '0; mem_finish = 1'b0;
        step(); step();
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL rst_gnt got=%b exp=000", gnt); end
        checks++; if ({done, err} !== 6'b0) begin failures++; $display("FAIL rst_done_err got=%b exp=0", {done, err}); end
        checks++; if ({mem_enable, mem_write} !== 2'b00) begin failures++; $display("FAIL rst_en_wr got=%b exp=00", {mem_enable, mem_write}); end
        checks++; if ({mem_address, mem_offset, mem_wdata} !== 48'h0) begin failures++; $display("FAIL rst_bus got=%h exp=0", {mem_address, mem_offset, mem_wdata}); end
        reset = 1'b0;
        step();
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL idle_gnt got=%b exp=000", gnt); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_order [4];
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (gnt !== exp_order[i]) begin failures++; $display("FAIL ct_gnt[%0d] got=%b exp=%b", i, gnt, exp_order[i]); end
            step();
            checks++; if (mem_enable !== 1'b1) begin failures++; $display("FAIL ct_en[%0d] got=%b exp=1", i, mem_enable); end
            step();
            mem_finish = 1'b1;
            step();
            mem_finish = 1'b0;
            checks++; if (done !== exp_order[i]) begin failures++; $display("FAIL ct_done[%0d] got=%b exp=%b", i, done, exp_order[i]); end
            step();
            checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL ct_gap[%0d] got=%b exp=000", i, gnt); end
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_single_read();
        mem_finish = 1'b1;  // must be ignored while idle
        step();
        mem_finish = 1'b0;
        checks++; if ({gnt, done} !== 6'b0) begin failures++; $display("FAIL sr_idle_finish got=%b exp=0", {gnt, done}); end
        req = 3'b001; req_addr[15:0] = 16'h0019; req_offset[15:0] = 16'd10; req_write[0] = 1'b0;
        step();
        req = 3'b000;  // dropping req must not abort
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL sr_gnt got=%b exp=001", gnt); end
        checks++; if (mem_enable !== 1'b0) begin failures++; $display("FAIL sr_en_early got=%b exp=0", mem_enable); end
        step();
        checks++; if ({mem_enable, mem_write} !== 2'b10) begin failures++; $display("FAIL sr_en got=%b exp=10", {mem_enable, mem_write}); end
        checks++; if (mem_address !== 16'h0019) begin failures++; $display("FAIL sr_addr got=%h exp=0019", mem_address); end
        checks++; if (mem_offset !== 16'd10) begin failures++; $display("FAIL sr_off got=%0d exp=10", mem_offset); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({mem_enable, done} !== 4'b1000) begin failures++; $display("FAIL sr_wait[%0d] got=%b exp=1000", i, {mem_enable, done}); end
        end
        step();
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;
        checks++; if (done !== 3'b001) begin failures++; $display("FAIL sr_done got=%b exp=001", done); end
        checks++; if (err !== 3'b000) begin failures++; $display("FAIL sr_err got=%b exp=000", err); end
        step();
        checks++; if ({gnt, done, mem_enable} !== 7'b0) begin failures++; $display("FAIL sr_release got=%b exp=0", {gnt, done, mem_enable}); end
    endtask

    task automatic test_write_latch();
        req = 3'b010; req_addr[31:16] = 16'h1234; req_write[1] = 1'b1; req_wdata[31:16] = 16'h00AB;
        step();
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL wl_gnt got=%b exp=010", gnt); end
        req = 3'b000; req_wdata[31:16] = 16'hFFFF; req_addr[31:16] = 16'hBEEF; req_write[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({mem_enable, mem_write} !== 2'b11) begin failures++; $display("FAIL wl_wr[%0d] got=%b exp=11", i, {mem_enable, mem_write}); end
            checks++; if (mem_wdata !== 16'h00AB) begin failures++; $display("FAIL wl_wdata[%0d] got=%h exp=00ab", i, mem_wdata); end
            checks++; if (mem_address !== 16'h1234) begin failures++; $display("FAIL wl_addr[%0d] got=%h exp=1234", i, mem_address); end
        end
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;
        checks++; if (done !== 3'b010) begin failures++; $display("FAIL wl_done got=%b exp=010", done); end
        step();
    endtask

    task automatic test_timeout();
        req = 3'b101;  // rr pointer is at 2 here
        step();
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL to_gnt got=%b exp=100", gnt); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if ({mem_enable, err} !== 4'b1000) begin failures++; $display("FAIL to_wait[%0d] got=%b exp=1000", i, {mem_enable, err}); end
        end
        step();
        checks++; if (err !== 3'b100) begin failures++; $display("FAIL to_err got=%b exp=100", err); end
        checks++; if ({done, mem_enable} !== 4'b0) begin failures++; $display("FAIL to_done_en got=%b exp=0", {done, mem_enable}); end
        step();
        checks++; if ({gnt, err} !== 6'b0) begin failures++; $display("FAIL to_idle got=%b exp=0", {gnt, err}); end
        step();
        req = 3'b000;
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL to_next got=%b exp=001", gnt); end
        step();
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;
        checks++; if (done !== 3'b001) begin failures++; $display("FAIL to_next_done got=%b exp=001", done); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        req = 3'b010;
        step();
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL rw_gnt got=%b exp=010", gnt); end
        req = 3'b000;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0; mem_finish = 1'b1;
        checks++; if ({gnt, done, err, mem_enable, mem_write} !== 11'b0) begin failures++; $display("FAIL rw_rst got=%b exp=0", {gnt, done, err, mem_enable, mem_write}); end
        checks++; if (mem_address !== 16'h0) begin failures++; $display("FAIL rw_addr got=%h exp=0000", mem_address); end
        step();
        mem_finish = 1'b0;
        checks++; if ({gnt, done, err, mem_enable} !== 10'b0) begin failures++; $display("FAIL rw_late_finish got=%b exp=0", {gnt, done, err, mem_enable}); end
        req = 3'b111;
        step();
        req = 3'b000;
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL rw_first_gnt got=%b exp=001", gnt); end
        step();
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;
        checks++; if (done !== 3'b001) begin failures++; $display("FAIL rw_done got=%b exp=001", done); end
        step();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_write_latch();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
